// File: rtl/bt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : bt_uart_tx
// Brief    : FIFO-buffered UART transmitter with configurable word width, baud
//            divisor and stop bits. The parity bit is added when the macro
//            BT_UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module bt_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_W-1:0]                 din,
    input  logic                              wr_en,
    input  logic                              parity_odd,
    output logic                              tx,
    output logic                              busy,
    output logic                              done,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_BIT_W = $clog2(DATA_W);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic [c_LVL_W-1:0] c_DEPTH     = c_LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef BT_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_has_word;
    logic [DATA_W-1:0]  w_head;

    // ------------------------------------------------------------------------
    // Transmit datapath and FSM
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BIT_W-1:0] r_bit_idx;
    logic [c_BIT_W-1:0] w_bit_idx_next;
    logic [DATA_W-1:0]  r_shift;
    logic               r_tx;
    logic               r_done;
    logic               w_done;
    logic               w_tick;
    logic               w_shift_en;
    logic               w_tx_next;

`ifdef BT_UART_TX_PARITY_EN
    logic               r_parity;
`else
    logic               w_unused_parity;
    assign w_unused_parity = parity_odd;
`endif

    assign w_full     = (r_level == c_DEPTH);
    assign w_push     = wr_en && !w_full;
    assign w_has_word = (r_level != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tick     = (r_cnt == c_CNT_LAST);

    // A write seen while full is dropped even if a pop frees a slot this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        w_shift_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_has_word) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == c_DATA_LAST) begin
                        w_bit_idx_next = '0;
`ifdef BT_UART_TX_PARITY_EN
                        w_state_next   = S_PARITY;
`else
                        w_state_next   = S_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
`ifdef BT_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_next   = S_STOP;
                    w_bit_idx_next = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_idx == c_STOP_LAST) begin
                        w_done         = 1'b1;
                        w_bit_idx_next = '0;
                        // Chain straight into the next frame with no idle gap.
                        if (w_has_word) begin
                            w_pop        = 1'b1;
                            w_state_next = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[0];
`ifdef BT_UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // tx lags the state by one cycle so every bit, including start, is
    // held for exactly CLKS_PER_BIT cycles on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_done    <= w_done;
            r_tx      <= w_tx_next;
            if (w_pop || (r_state == S_IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pop) begin
                r_shift <= w_head;
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            end
        end
    end

`ifdef BT_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= (^w_head) ^ parity_odd;
        end
    end
`endif

    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign full     = w_full;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_uart_tx
// Brief    : Self-checking bench for bt_uart_tx; a queue-based line model
//            is compared every cycle, plus directed frame tables and corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bt_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int DW2   = 7;
    localparam int SB2   = 2;
`ifdef BT_UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL  = (1 + DW + PB + SB) * CPB;
    localparam int FL2 = (1 + DW2 + PB + SB2) * CPB;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    din;
    logic             wr_en;
    logic             parity_odd;
    logic             tx, busy, done, full, overflow;
    logic [LVL_W-1:0] level;

    logic [DW2-1:0]   din2;
    logic             wr_en2;
    logic             tx2, busy2, done2, full2, overflow2;
    logic [LVL_W-1:0] level2;

    always #5 clk = ~clk;

    bt_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .parity_odd(parity_odd),
        .tx(tx), .busy(busy), .done(done), .full(full), .level(level), .overflow(overflow)
    );

    bt_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW2), .STOP_BITS(SB2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .wr_en(wr_en2), .parity_odd(parity_odd),
        .tx(tx2), .busy(busy2), .done(done2), .full(full2), .level(level2), .overflow(overflow2)
    );

    // Reference model: a word queue, a countdown to the end of the current
    // frame, and the expected line level as a stream of per-cycle bits.
    logic [DW-1:0] m_q[$];
    bit            m_stream[$];
    int            m_remain = 0;
    bit            m_tx = 1'b1;
    bit            m_done = 1'b0;
    bit            m_ovf = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put_bit(input bit b);
        for (int k = 0; k < CPB; k++) m_stream.push_back(b);
    endtask

    task automatic model_edge();
        int            n;
        bit            do_pop;
        logic [DW-1:0] w;
        if (rst) begin
            m_q.delete();
            m_stream.delete();
            m_remain = 0;
            m_tx     = 1'b1;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            return;
        end
        n      = m_q.size();
        do_pop = (n > 0) && (m_remain <= 1);
        m_done = (m_remain == 1);
        m_ovf  = wr_en && (n == DEPTH);
        m_tx   = (m_stream.size() > 0) ? m_stream.pop_front() : 1'b1;
        if (do_pop) begin
            w = m_q.pop_front();
            put_bit(1'b0);
            for (int i = 0; i < DW; i++) put_bit(w[i]);
            if (PB == 1) put_bit((^w) ^ parity_odd);
            for (int s = 0; s < SB; s++) put_bit(1'b1);
            m_remain = FL;
        end else if (m_remain > 0) begin
            m_remain--;
        end
        if (wr_en && (n != DEPTH)) m_q.push_back(din);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tx", tx, m_tx);
        chk("busy", busy, (m_remain > 0) ? 1 : 0);
        chk("done", done, m_done);
        chk("level", level, m_q.size());
        chk("full", full, (m_q.size() == DEPTH) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || (level != 0)) && (n < budget)) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", (busy || (level != 0)) ? 1 : 0, 0);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        logic          pod;
        logic          exp_par;
        int            exp_len;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dcount, didx, nb, ovc, dn, last, lowcnt;
        bit fullseen;
        bit exp_bits[16];

        vecs[0] = '{din: 8'h55, pod: 1'b0, exp_par: 1'b0, exp_len: FL};
        vecs[1] = '{din: 8'hA3, pod: 1'b0, exp_par: 1'b0, exp_len: FL};
        vecs[2] = '{din: 8'hA3, pod: 1'b1, exp_par: 1'b1, exp_len: FL};
        vecs[3] = '{din: 8'h00, pod: 1'b1, exp_par: 1'b1, exp_len: FL};
        vecs[4] = '{din: 8'hFF, pod: 1'b0, exp_par: 1'b0, exp_len: FL};
        vecs[5] = '{din: 8'h80, pod: 1'b0, exp_par: 1'b1, exp_len: FL};
        vecs[6] = '{din: 8'h07, pod: 1'b1, exp_par: 1'b0, exp_len: FL};

        rst = 1'b1; din = '0; wr_en = 1'b0; parity_odd = 1'b0;
        din2 = '0; wr_en2 = 1'b0;
        repeat (2) step();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        rst = 1'b0;
        step();

        // Directed single frames
        for (int v = 0; v < 7; v++) begin
            wait_idle(1000);
            exp_bits[0] = 1'b0;
            for (int i = 0; i < DW; i++) exp_bits[1 + i] = vecs[v].din[i];
            nb = 1 + DW;
            if (PB == 1) begin
                exp_bits[nb] = vecs[v].exp_par;
                nb++;
            end
            for (int s = 0; s < SB; s++) begin
                exp_bits[nb] = 1'b1;
                nb++;
            end
            din = vecs[v].din; parity_odd = vecs[v].pod; wr_en = 1'b1;
            step();
            wr_en = 1'b0;
            dcount = 0; didx = -1;
            for (int i = 0; i < vecs[v].exp_len + 4; i++) begin
                step();
                if (done) begin
                    dcount++;
                    if (didx < 0) didx = i;
                end
                if ((i >= 1) && (i <= vecs[v].exp_len) && (((i - 1) % CPB) == CPB / 2))
                    chk($sformatf("vec%0d_bit%0d", v, (i - 1) / CPB), tx, exp_bits[(i - 1) / CPB]);
            end
            chk($sformatf("vec%0d_done_cnt", v), dcount, 1);
            chk($sformatf("vec%0d_done_at", v), didx, vecs[v].exp_len);
            chk($sformatf("vec%0d_busy_end", v), busy, 0);
        end

        // Back-to-back frames
        wait_idle(1000);
        wr_en = 1'b1;
        din = 8'h01; step();
        din = 8'h02; step();
        din = 8'h03; step();
        wr_en = 1'b0;
        dn = 0; last = -1;
        for (int i = 0; i < 3 * FL + 20; i++) begin
            step();
            if (done) begin
                if (last >= 0) chk("b2b_done_gap", i - last, FL);
                last = i;
                dn++;
            end
        end
        chk("b2b_done_cnt", dn, 3);

        // Overflow with six consecutive writes
        wait_idle(1000);
        ovc = 0; fullseen = 1'b0; dn = 0;
        wr_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            din = DW'($urandom);
            step();
            ovc += overflow;
            fullseen |= full;
            dn += done;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6 * FL; i++) begin
            step();
            ovc += overflow;
            fullseen |= full;
            dn += done;
        end
        chk("ovf_pulses", ovc, 1);
        chk("ovf_full_seen", fullseen, 1);
        chk("ovf_frames", dn, 5);

        // Two stop bits, seven data bits on the second instance
        wait_idle(1000);
        parity_odd = 1'b0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DW2; i++) exp_bits[1 + i] = 1'b1;
        nb = 1 + DW2;
        if (PB == 1) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        for (int s = 0; s < SB2; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        din2 = 7'h7F; wr_en2 = 1'b1;
        step();
        wr_en2 = 1'b0;
        didx = -1; lowcnt = 0;
        for (int i = 0; i < FL2 + 4; i++) begin
            step();
            if (done2 && (didx < 0)) didx = i;
            if (!tx2) lowcnt++;
            if ((i >= 1) && (i <= FL2) && (((i - 1) % CPB) == CPB / 2))
                chk($sformatf("stop2_bit%0d", (i - 1) / CPB), tx2, exp_bits[(i - 1) / CPB]);
        end
        chk("stop2_done_at", didx, FL2);
        chk("stop2_low_cycles", lowcnt, CPB);
        chk("stop2_busy_end", busy2, 0);

        // Asynchronous reset in the middle of DATA with two words queued
        wait_idle(1000);
        wr_en = 1'b1;
        din = 8'hC3; step();
        din = 8'h3C; step();
        din = 8'h5A; step();
        wr_en = 1'b0;
        repeat (3 * CPB) step();
        chk("prerst_level", level, 2);
        chk("prerst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_level", level, 0);
        step();
        step();
        rst = 1'b0;
        dn = 0;
        din = 8'h96; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < FL + 4; i++) begin
            step();
            dn += done;
        end
        chk("post_rst_frames", dn, 1);

        // Randomised traffic: sparse, then bursty enough to overflow
        for (int c = 0; c < 3000; c++) begin
            wr_en = ($urandom_range(0, 99) < ((c < 1500) ? 3 : 40));
            din   = DW'($urandom);
            if ($urandom_range(0, 63) == 0) parity_odd = ~parity_odd;
            step();
        end
        wr_en = 1'b0;
        wait_idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
